serial_max_frame_ctrl: RTL and testbench
========================================

SERIAL_MAX_FRAME_CTRL -- requirements
Module: serial_max_frame_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, sample and result width in bits (signed two's complement).
REQ-002 Parameter FRAME_LEN, default 8, samples per frame; legal range 2..256.
REQ-003 Parameter IDX_W, default $clog2(FRAME_LEN), width of the sample counter and of argmax.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to begin a frame.
REQ-007 busy  output  1  high in ACCUM and DONE.
REQ-008 in_valid  input  1  sample present on in.
REQ-009 in_ready  output  1  controller accepts a sample this cycle.
REQ-010 in  input  WIDTH  signed sample.
REQ-011 out_valid  output  1  frame result available.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 max  output  WIDTH  signed frame maximum.
REQ-014 argmax  output  IDX_W  zero-based index of the maximum within the frame (present only with the macro, see Configuration).

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-016 A sample is accepted on a cycle where in_valid && in_ready; in_ready SHALL equal (state==ACCUM), combinationally, with no dependency on in_valid.
REQ-017 IDLE: when start=1, go to ACCUM; clear the counter to 0; load max with -2^(WIDTH-1); clear argmax to 0.
REQ-018 ACCUM: on an accepted sample, if the counter is 0 or in > max (signed, strict), load max<=in and argmax<=counter; then increment the counter.
REQ-019 Ties SHALL keep the earliest index (strict comparison).
REQ-020 ACCUM: a cycle without acceptance SHALL leave all state unchanged.
REQ-021 ACCUM: the sample accepted with counter==FRAME_LEN-1 SHALL move the FSM to DONE.
REQ-022 out_valid SHALL equal (state==DONE), so it rises exactly one cycle after the final sample is accepted.
REQ-023 DONE: max and argmax SHALL be held stable while out_valid=1 && out_ready=0.
REQ-024 DONE with out_ready=1: go to IDLE; if start=1 on the same cycle, go directly to ACCUM with the IDLE initialisation of REQ-017 instead.
REQ-025 start SHALL be ignored in ACCUM, and in DONE while out_ready=0.
REQ-026 max and argmax SHALL keep the last frame's result in IDLE until the next start.
REQ-027 The counter SHALL never exceed FRAME_LEN-1 and SHALL never wrap inside a frame.

Reset
REQ-028 rst=1 SHALL, on the next clock edge and from any state, set state=IDLE, counter=0, max=-2^(WIDTH-1) and argmax=0.
REQ-029 In the cycle after reset, out_valid, in_ready and busy SHALL all be 0.
REQ-030 rst SHALL take priority over start, in_valid and out_ready.
REQ-031 A frame interrupted by reset SHALL be discarded, with no out_valid pulse.

Configuration
REQ-032 Macro SERIAL_MAX_FRAME_CTRL_ARGMAX_EN defined: the argmax port and index register SHALL exist and behave per REQ-018/019/024/028.
REQ-033 Macro undefined: the argmax port and its register SHALL be absent; all other ports, timing and max behaviour SHALL be identical.

Verification (WIDTH=4, FRAME_LEN=4, macro defined unless noted)
REQ-034 start, then samples 3,-2,7,1 on consecutive cycles -> out_valid=1 the cycle after 1 is accepted, max=7, argmax=2.
REQ-035 Frame -8,-8,-8,-8 -> max=-8, argmax=0; frame 5,5,2,5 -> max=5, argmax=0.
REQ-036 Frame 1,2,3,4 with in_valid low 2 cycles between samples -> only 4 acceptances, max=4, argmax=3; in_ready held 1 throughout ACCUM.
REQ-037 out_ready held 0 for 3 cycles in DONE with start pulsed -> max and argmax stable, in_ready=0, no new frame; then out_ready=1 with start=1 -> next cycle ACCUM, busy=1, out_valid=0.
REQ-038 rst after 2 accepted samples (6,7) -> next cycle IDLE, max=-8, argmax=0, no out_valid; a following frame -1,-3,-2,-4 -> max=-1, argmax=0.
REQ-039 Rerun REQ-034 with the macro undefined -> max=7, same cycle timing, no argmax port.

Source files
------------

// File: rtl/serial_max_frame_ctrl_if.sv
// Handshake bundle for serial_max_frame_ctrl: frame start, sample stream and result.
// The argmax signal exists only when SERIAL_MAX_FRAME_CTRL_ARGMAX_EN is defined.
interface serial_max_frame_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 3
);
    logic                    start;
    logic                    busy;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] max;
`ifdef SERIAL_MAX_FRAME_CTRL_ARGMAX_EN
    logic        [IDX_W-1:0] argmax;
`endif

    // Producer/consumer side of the controller
    modport master (
        output start, in_valid, in, out_ready,
        input  busy, in_ready, out_valid, max
`ifdef SERIAL_MAX_FRAME_CTRL_ARGMAX_EN
        , input argmax
`endif
    );

    // Controller side
    modport slave (
        input  start, in_valid, in, out_ready,
        output busy, in_ready, out_valid, max
`ifdef SERIAL_MAX_FRAME_CTRL_ARGMAX_EN
        , output argmax
`endif
    );
endinterface

// File: rtl/serial_max_frame_ctrl.sv
// Serial frame maximum finder: accepts FRAME_LEN signed samples, reports max (and argmax
// when SERIAL_MAX_FRAME_CTRL_ARGMAX_EN is defined), holds the result until taken.
module serial_max_frame_ctrl #(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 8,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_max_frame_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic signed [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic        [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t                  state_reg;
    logic        [IDX_W-1:0] count_reg;
    logic signed [WIDTH-1:0] max_reg;
`ifdef SERIAL_MAX_FRAME_CTRL_ARGMAX_EN
    logic        [IDX_W-1:0] argmax_reg;
`endif

    logic take_sample;
    logic new_max;

    assign take_sample = bus.in_valid && (state_reg == ACCUM);
    // The first sample of a frame always loads, so the reset value of max never wins
    assign new_max     = (count_reg == '0) || (bus.in > max_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            max_reg    <= MIN_VAL;
`ifdef SERIAL_MAX_FRAME_CTRL_ARGMAX_EN
            argmax_reg <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg  <= ACCUM;
                        count_reg  <= '0;
                        max_reg    <= MIN_VAL;
`ifdef SERIAL_MAX_FRAME_CTRL_ARGMAX_EN
                        argmax_reg <= '0;
`endif
                    end
                end
                ACCUM: begin
                    if (take_sample) begin
                        if (new_max) begin
                            max_reg    <= bus.in;
`ifdef SERIAL_MAX_FRAME_CTRL_ARGMAX_EN
                            argmax_reg <= count_reg;
`endif
                        end
                        // Counter parks at the last index instead of wrapping
                        if (count_reg == LAST_IDX) begin
                            state_reg <= DONE;
                        end else begin
                            count_reg <= count_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        if (bus.start) begin
                            state_reg  <= ACCUM;
                            count_reg  <= '0;
                            max_reg    <= MIN_VAL;
`ifdef SERIAL_MAX_FRAME_CTRL_ARGMAX_EN
                            argmax_reg <= '0;
`endif
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.in_ready  = (state_reg == ACCUM);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.max       = max_reg;
`ifdef SERIAL_MAX_FRAME_CTRL_ARGMAX_EN
    assign bus.argmax    = argmax_reg;
`endif
endmodule

// File: tb/tb_serial_max_frame_ctrl.sv
// Bench for serial_max_frame_ctrl (WIDTH=4, FRAME_LEN=4): vector table, corner sequences,
// then random traffic against a frame-level reference model.
module tb_serial_max_frame_ctrl;
    localparam int WIDTH     = 4;
    localparam int FRAME_LEN = 4;
    localparam int IDX_W     = 2;

    logic clk;
    logic rst;

    serial_max_frame_ctrl_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

    serial_max_frame_ctrl #(
        .WIDTH    (WIDTH),
        .FRAME_LEN(FRAME_LEN),
        .IDX_W    (IDX_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: a frame is just the list of samples accepted so far
    bit               collecting = 1'b0;
    bit               holding    = 1'b0;
    int               frame_q[$];
    int               exp_max    = -8;
    int               exp_arg    = 0;

    typedef struct {
        bit st;
        bit iv;
        int d;
        bit ordy;
        bit rs;
        bit eb;
        bit eir;
        bit eov;
        int emax;
        int earg;
    } vec_t;

    vec_t vec_q[$];

    task automatic chk(input string name, input int act, input int req);
        total_cnt++;
        if (act != req) begin
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic void begin_frame();
        collecting = 1'b1;
        frame_q.delete();
        exp_max = -8;
        exp_arg = 0;
    endfunction

    // Largest value so far, earliest position on ties
    function automatic void recompute();
        exp_max = frame_q[0];
        exp_arg = 0;
        for (int k = 1; k < frame_q.size(); k++) begin
            if (frame_q[k] > exp_max) begin
                exp_max = frame_q[k];
                exp_arg = k;
            end
        end
    endfunction

    function automatic void model_step(input bit st, input bit iv, input int d,
                                       input bit ordy, input bit rs);
        if (rs) begin
            collecting = 1'b0;
            holding    = 1'b0;
            frame_q.delete();
            exp_max = -8;
            exp_arg = 0;
        end else if (collecting) begin
            if (iv) begin
                frame_q.push_back(d);
                recompute();
                if (frame_q.size() == FRAME_LEN) begin
                    collecting = 1'b0;
                    holding    = 1'b1;
                    $display("frame done: samples=%0d,%0d,%0d,%0d max=%0d argmax=%0d",
                             frame_q[0], frame_q[1], frame_q[2], frame_q[3], exp_max, exp_arg);
                end
            end
        end else if (holding) begin
            if (ordy) begin
                holding = 1'b0;
                if (st) begin
                    begin_frame();
                end
            end
        end else if (st) begin
            begin_frame();
        end
    endfunction

    // Drive at the falling edge, let one rising edge act, compare at the next falling edge
    task automatic apply(input bit st, input bit iv, input int d, input bit ordy, input bit rs);
        logic [3:0] dv;
        dv            = d[3:0];
        bus.start     = st;
        bus.in_valid  = iv;
        bus.in        = dv;
        bus.out_ready = ordy;
        rst           = rs;
        @(posedge clk);
        model_step(st, iv, int'($signed(dv)), ordy, rs);
        @(negedge clk);
        chk("busy", int'(bus.busy), int'(collecting || holding));
        chk("in_ready", int'(bus.in_ready), int'(collecting));
        chk("out_valid", int'(bus.out_valid), int'(holding));
        chk("max", int'(bus.max), exp_max);
`ifdef SERIAL_MAX_FRAME_CTRL_ARGMAX_EN
        chk("argmax", int'(bus.argmax), exp_arg);
`endif
    endtask

    function automatic void row(input int st, input int iv, input int d, input int ordy,
                                input int rs, input int eb, input int eir, input int eov,
                                input int emax, input int earg);
        vec_t v;
        v.st = st[0]; v.iv = iv[0]; v.d = d; v.ordy = ordy[0]; v.rs = rs[0];
        v.eb = eb[0]; v.eir = eir[0]; v.eov = eov[0]; v.emax = emax; v.earg = earg;
        vec_q.push_back(v);
    endfunction

    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in = '0; bus.out_ready = 1'b0;
        rst = 1'b1;

        // Reset, then frame 3,-2,7,1
        row(0,0, 0,0,1, 0,0,0,-8,0);
        row(1,0, 0,0,0, 1,1,0,-8,0);
        row(0,1, 3,0,0, 1,1,0, 3,0);
        row(0,1,-2,0,0, 1,1,0, 3,0);
        row(0,1, 7,0,0, 1,1,0, 7,2);
        row(0,1, 1,0,0, 1,0,1, 7,2);
        row(0,0, 0,0,0, 1,0,1, 7,2);
        row(0,0, 0,1,0, 0,0,0, 7,2);
        row(0,1, 5,0,0, 0,0,0, 7,2);
        // All-minimum frame, then back-to-back frame with ties
        row(1,0, 0,0,0, 1,1,0,-8,0);
        row(0,1,-8,0,0, 1,1,0,-8,0);
        row(0,1,-8,0,0, 1,1,0,-8,0);
        row(0,1,-8,0,0, 1,1,0,-8,0);
        row(0,1,-8,0,0, 1,0,1,-8,0);
        row(1,0, 0,1,0, 1,1,0,-8,0);
        row(0,1, 5,0,0, 1,1,0, 5,0);
        row(0,1, 5,0,0, 1,1,0, 5,0);
        row(0,1, 2,0,0, 1,1,0, 5,0);
        row(0,1, 5,0,0, 1,0,1, 5,0);
        row(0,0, 0,1,0, 0,0,0, 5,0);

        @(negedge clk);
        for (int i = 0; i < vec_q.size(); i++) begin
            apply(vec_q[i].st, vec_q[i].iv, vec_q[i].d, vec_q[i].ordy, vec_q[i].rs);
            chk($sformatf("v%0d_busy", i), int'(bus.busy), int'(vec_q[i].eb));
            chk($sformatf("v%0d_in_ready", i), int'(bus.in_ready), int'(vec_q[i].eir));
            chk($sformatf("v%0d_out_valid", i), int'(bus.out_valid), int'(vec_q[i].eov));
            chk($sformatf("v%0d_max", i), int'(bus.max), vec_q[i].emax);
`ifdef SERIAL_MAX_FRAME_CTRL_ARGMAX_EN
            chk($sformatf("v%0d_argmax", i), int'(bus.argmax), vec_q[i].earg);
`endif
        end

        // Frame 1,2,3,4 with two idle cycles between samples
        apply(1, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            apply(0, 1, k, 0, 0);
            if (k < 4) begin
                for (int g = 0; g < 2; g++) begin
                    apply(0, 0, 9, 0, 0);
                    chk("gap_in_ready", int'(bus.in_ready), 1);
                    chk("gap_out_valid", int'(bus.out_valid), 0);
                end
            end
        end
        chk("gap_done", int'(bus.out_valid), 1);
        chk("gap_max", int'(bus.max), 4);
`ifdef SERIAL_MAX_FRAME_CTRL_ARGMAX_EN
        chk("gap_argmax", int'(bus.argmax), 3);
`endif

        // Stall in DONE with start pulsed, then release with start
        for (int k = 0; k < 3; k++) begin
            apply(k == 1, 0, 0, 0, 0);
            chk("hold_max", int'(bus.max), 4);
            chk("hold_in_ready", int'(bus.in_ready), 0);
            chk("hold_out_valid", int'(bus.out_valid), 1);
        end
        apply(1, 0, 0, 1, 0);
        chk("restart_busy", int'(bus.busy), 1);
        chk("restart_in_ready", int'(bus.in_ready), 1);
        chk("restart_out_valid", int'(bus.out_valid), 0);

        // Reset in the middle of a frame, then a negative frame
        apply(0, 1, 6, 0, 0);
        apply(0, 1, 7, 1, 0);
        apply(1, 1, 5, 1, 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_max", int'(bus.max), -8);
        apply(0, 1, 3, 0, 0);
        chk("rst_no_accept", int'(bus.in_ready), 0);
        apply(1, 0, 0, 0, 0);
        apply(0, 1, -1, 0, 0);
        apply(0, 1, -3, 0, 0);
        apply(0, 1, -2, 0, 0);
        apply(0, 1, -4, 0, 0);
        chk("neg_out_valid", int'(bus.out_valid), 1);
        chk("neg_max", int'(bus.max), -1);
`ifdef SERIAL_MAX_FRAME_CTRL_ARGMAX_EN
        chk("neg_argmax", int'(bus.argmax), 0);
`endif
        apply(0, 0, 0, 1, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            apply($urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) < 7,
                  int'($urandom_range(0, 15)),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 2);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
